// File: rtl/plca_txop_claim_table_pkg.sv
// Shared definitions for the PLCA TXOP claim table: command op codes,
// per-entry claim encodings, controller states and the pick-start LFSR step.
package plca_txop_claim_table_pkg;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_CLAIM_HARD = 3'd1;
    localparam logic [2:0] OP_CLAIM_SOFT = 3'd2;
    localparam logic [2:0] OP_CLEAR_SOFT = 3'd3;
    localparam logic [2:0] OP_CLEAR_ALL  = 3'd4;
    localparam logic [2:0] OP_PICK_FREE  = 3'd5;

    typedef enum logic [1:0] {
        ENT_FREE = 2'b00,
        ENT_SOFT = 2'b01,
        ENT_HARD = 2'b10
    } entry_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_PICK  = 2'd2
    } state_e;

    // Fibonacci step for x^8+x^6+x^5+x^4+1; a nonzero value never maps to zero.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/plca_lfsr8.sv
// Free-running 8-bit maximal-length LFSR; shared by TXOP pick and beacon jitter.
module plca_lfsr8
    import plca_txop_claim_table_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= lfsr8_next(q);
        end
    end

endmodule

// File: rtl/plca_txop_claim_table.sv
// PLCA TXOP claim table: per-ID FREE/SOFT/HARD state with single-cycle claims,
// sequential clear walks and an LFSR-seeded circular search for a free ID.
module plca_txop_claim_table
    import plca_txop_claim_table_pkg::*;
#(
    parameter int         NUM_TXOP  = 255,
    parameter int         ID_W      = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    // A command transfers on a rising edge where cmd_valid && cmd_ready; cmd_op and
    // cmd_id must be held stable while cmd_valid is high and cmd_ready is low.
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [ID_W-1:0] cmd_id,
    output logic            rsp_valid,
    output logic            rsp_found,
    output logic [ID_W-1:0] rsp_id,
    input  logic [ID_W-1:0] q_id,
    output logic            q_hard,
    output logic            q_soft,
    output logic [ID_W-1:0] max_hard,
    output logic [ID_W-1:0] hard_cnt,
    output logic [ID_W-1:0] soft_cnt,
    output logic [1:0]      dbg_state
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_TXOP);
    localparam logic [ID_W-1:0] ONE     = ID_W'(1);

    state_e          state, state_d;
    entry_e          tbl [1:NUM_TXOP];
    entry_e          tgt_entry, q_entry, new_entry;
    logic            tbl_we;
    logic [ID_W-1:0] tgt_id, idx, idx_d, scan_cnt, scan_d, pick_raw, pick_start, idx_wrap;
    logic [ID_W-1:0] hard_cnt_d, soft_cnt_d, max_hard_d, rsp_id_d;
    logic            rsp_valid_d, rsp_found_d, clear_all, clear_all_d, accept, id_ok;
    logic [7:0]      lfsr;

    plca_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign cmd_ready  = (state == ST_IDLE);
    assign dbg_state  = state;
    assign accept     = cmd_valid && cmd_ready;
    assign id_ok      = (cmd_id != '0) && (cmd_id <= LAST_ID);
    assign pick_raw   = ID_W'(lfsr);
    assign pick_start = ((pick_raw == '0) || (pick_raw > LAST_ID)) ? ONE : pick_raw;
    assign idx_wrap   = (idx == LAST_ID) ? ONE : idx + ONE;
    // Only one entry is touched per cycle: the command target when idle, the walk index otherwise.
    assign tgt_id     = (state == ST_IDLE) ? cmd_id : idx;

    always_comb begin
        tgt_entry = ENT_FREE;
        q_entry   = ENT_FREE;
        for (int i = 1; i <= NUM_TXOP; i++) begin
            if (tgt_id == ID_W'(i)) tgt_entry = tbl[i];
            if (q_id == ID_W'(i))   q_entry   = tbl[i];
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        scan_d      = scan_cnt;
        clear_all_d = clear_all;
        tbl_we      = 1'b0;
        new_entry   = tgt_entry;
        hard_cnt_d  = hard_cnt;
        soft_cnt_d  = soft_cnt;
        max_hard_d  = max_hard;
        rsp_valid_d = 1'b0;
        rsp_found_d = 1'b0;
        rsp_id_d    = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_CLAIM_HARD: begin
                            rsp_valid_d = 1'b1;
                            rsp_id_d    = cmd_id;
                            if (id_ok) begin
                                rsp_found_d = 1'b1;
                                tbl_we      = 1'b1;
                                new_entry   = ENT_HARD;
                                if (tgt_entry == ENT_SOFT) soft_cnt_d = soft_cnt - ONE;
                                if (tgt_entry != ENT_HARD) hard_cnt_d = hard_cnt + ONE;
                                if (cmd_id > max_hard)     max_hard_d = cmd_id;
                            end
                        end
                        OP_CLAIM_SOFT: begin
                            rsp_valid_d = 1'b1;
                            rsp_id_d    = cmd_id;
                            if (id_ok && tgt_entry != ENT_HARD) begin
                                rsp_found_d = 1'b1;
                                if (tgt_entry == ENT_FREE) begin
                                    tbl_we     = 1'b1;
                                    new_entry  = ENT_SOFT;
                                    soft_cnt_d = soft_cnt + ONE;
                                end
                            end
                        end
                        OP_CLEAR_SOFT, OP_CLEAR_ALL: begin
                            state_d     = ST_CLEAR;
                            idx_d       = ONE;
                            clear_all_d = (cmd_op == OP_CLEAR_ALL);
                            if (cmd_op == OP_CLEAR_ALL) max_hard_d = '0;
                        end
                        OP_PICK_FREE: begin
                            state_d = ST_PICK;
                            idx_d   = pick_start;
                            scan_d  = ONE;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CLEAR: begin
                if (tgt_entry == ENT_SOFT) begin
                    tbl_we     = 1'b1;
                    new_entry  = ENT_FREE;
                    soft_cnt_d = soft_cnt - ONE;
                end else if (tgt_entry == ENT_HARD && clear_all) begin
                    tbl_we     = 1'b1;
                    new_entry  = ENT_FREE;
                    hard_cnt_d = hard_cnt - ONE;
                end
                if (idx == LAST_ID) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_found_d = 1'b1;
                end else begin
                    idx_d = idx + ONE;
                end
            end
            ST_PICK: begin
                if (tgt_entry == ENT_FREE) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_found_d = 1'b1;
                    rsp_id_d    = idx;
                end else if (scan_cnt == LAST_ID) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    idx_d  = idx_wrap;
                    scan_d = scan_cnt + ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            scan_cnt  <= '0;
            clear_all <= 1'b0;
            hard_cnt  <= '0;
            soft_cnt  <= '0;
            max_hard  <= '0;
            rsp_valid <= 1'b0;
            rsp_found <= 1'b0;
            rsp_id    <= '0;
            q_hard    <= 1'b0;
            q_soft    <= 1'b0;
            for (int i = 1; i <= NUM_TXOP; i++) tbl[i] <= ENT_FREE;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            scan_cnt  <= scan_d;
            clear_all <= clear_all_d;
            hard_cnt  <= hard_cnt_d;
            soft_cnt  <= soft_cnt_d;
            max_hard  <= max_hard_d;
            rsp_valid <= rsp_valid_d;
            rsp_found <= rsp_found_d;
            rsp_id    <= rsp_id_d;
            q_hard    <= (q_entry == ENT_HARD);
            q_soft    <= (q_entry == ENT_SOFT);
            for (int i = 1; i <= NUM_TXOP; i++) begin
                if (tbl_we && tgt_id == ID_W'(i)) tbl[i] <= new_entry;
            end
        end
    end

endmodule
